// File: rtl/fetch_unit.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | fetch_unit : MIPS instruction fetch, one outstanding read, 1-entry buffer |
// | Revision   : 1.0                                                          |
// +--------------------------------------------------------------------------+
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'hBFC0_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        inst_req,
  output logic [31:0] inst_addr,
  input  logic        inst_addr_ok,
  input  logic        inst_data_ok,
  input  logic [31:0] inst_rdata,
  output logic        if_valid,
  input  logic        if_ready,
  output logic [31:0] if_pc,
  output logic [31:0] if_inst,
  output logic        if_adel,
  input  logic        redir,
  input  logic [31:0] redir_pc
);

  typedef enum logic [1:0] {
    ST_REQ  = 2'd0,
    ST_WAIT = 2'd1,
    ST_HALT = 2'd2
  } state_t;

  state_t      state;
  logic [31:0] pc;
  logic        drop;
  logic        slot_free;
  logic        misaligned;

  assign slot_free  = !if_valid | if_ready;
  assign misaligned = (pc[1:0] != 2'b00);
  // Gated by rst_n so no request leaks out while reset is held.
  assign inst_req   = rst_n & (state == ST_REQ) & slot_free & !redir & !misaligned;
  assign inst_addr  = pc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_REQ;
      pc       <= RESET_PC;
      drop     <= 1'b0;
      if_valid <= 1'b0;
      if_pc    <= 32'd0;
      if_inst  <= 32'd0;
      if_adel  <= 1'b0;
    end else begin
      if (if_valid & if_ready)
        if_valid <= 1'b0;

      if (redir) begin
        pc       <= redir_pc;
        if_valid <= 1'b0;
        case (state)
          ST_WAIT: begin
            // Data returning in the redirect cycle belongs to the old stream.
            if (inst_data_ok) begin
              state <= ST_REQ;
              drop  <= 1'b0;
            end else begin
              drop  <= 1'b1;
            end
          end
          default: state <= ST_REQ;
        endcase
      end else begin
        case (state)
          ST_REQ: begin
            if (inst_req & inst_addr_ok) begin
              state <= ST_WAIT;
              pc    <= pc + 32'd4;
            end else if (misaligned & slot_free) begin
              if_valid <= 1'b1;
              if_pc    <= pc;
              if_inst  <= 32'd0;
              if_adel  <= 1'b1;
              state    <= ST_HALT;
            end
          end
          ST_WAIT: begin
            if (inst_data_ok) begin
              if (!drop) begin
                if_valid <= 1'b1;
                if_pc    <= pc - 32'd4;
                if_inst  <= inst_rdata;
                if_adel  <= 1'b0;
              end
              drop  <= 1'b0;
              state <= ST_REQ;
            end
          end
          default: state <= ST_HALT;
        endcase
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_fetch_unit : directed scoreboard bench for fetch_unit                  |
// | Revision      : 1.0                                                       |
// +--------------------------------------------------------------------------+
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic        inst_addr_ok = 1'b0;
  logic        inst_data_ok = 1'b0;
  logic [31:0] inst_rdata = 32'd0;
  logic        if_valid;
  logic        if_ready = 1'b0;
  logic [31:0] if_pc;
  logic [31:0] if_inst;
  logic        if_adel;
  logic        redir = 1'b0;
  logic [31:0] redir_pc = 32'd0;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        adel;
  } entry_t;

  entry_t exp_q[$];
  entry_t held;
  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  fetch_unit #(.RESET_PC(32'hBFC0_0000)) dut (
    .clk(clk), .rst_n(rst_n),
    .inst_req(inst_req), .inst_addr(inst_addr),
    .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
    .if_valid(if_valid), .if_ready(if_ready), .if_pc(if_pc), .if_inst(if_inst),
    .if_adel(if_adel), .redir(redir), .redir_pc(redir_pc)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Active edge plus 1 time unit: inputs are driven and outputs sampled here.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic pop_check(input string tag);
    entry_t e;
    if (exp_q.size() == 0) begin
      total++;
      bad++;
      $error("FAIL %s observed=output expected=empty_scoreboard", tag);
    end else begin
      e = exp_q.pop_front();
      held = e;
      chk({tag, ".valid"}, {31'd0, if_valid}, 32'd1);
      chk({tag, ".pc"}, if_pc, e.pc);
      chk({tag, ".inst"}, if_inst, e.inst);
      chk({tag, ".adel"}, {31'd0, if_adel}, {31'd0, e.adel});
    end
  endtask

  initial begin
    #2 rst_n = 1'b0;
    tick(); tick();
    chk("rst.req", {31'd0, inst_req}, 32'd0);
    chk("rst.valid", {31'd0, if_valid}, 32'd0);
    chk("rst.pc", if_pc, 32'd0);
    chk("rst.inst", if_inst, 32'd0);
    chk("rst.adel", {31'd0, if_adel}, 32'd0);
    chk("rst.addr", inst_addr, 32'hBFC0_0000);

    // 1: first fetch with zero-wait memory
    rst_n = 1'b1;
    inst_addr_ok = 1'b1;
    settle();
    chk("t1.req", {31'd0, inst_req}, 32'd1);
    chk("t1.addr", inst_addr, 32'hBFC0_0000);
    tick();
    inst_addr_ok = 1'b0;
    inst_data_ok = 1'b1; inst_rdata = 32'h2402_0001;
    exp_q.push_back('{pc: 32'hBFC0_0000, inst: 32'h2402_0001, adel: 1'b0});
    settle();
    chk("t1.req_wait", {31'd0, inst_req}, 32'd0);
    tick();
    inst_data_ok = 1'b0;
    settle();
    pop_check("t1.out");
    chk("t1.next_addr", inst_addr, 32'hBFC0_0004);

    // 2: decode stall keeps the entry and blocks requests
    for (int i = 0; i < 5; i++) begin
      chk("t2.valid", {31'd0, if_valid}, 32'd1);
      chk("t2.pc", if_pc, held.pc);
      chk("t2.inst", if_inst, held.inst);
      chk("t2.req", {31'd0, inst_req}, 32'd0);
      tick();
    end
    if_ready = 1'b1;
    inst_addr_ok = 1'b1;
    settle();
    chk("t2.req_rise", {31'd0, inst_req}, 32'd1);
    chk("t2.addr", inst_addr, 32'hBFC0_0004);
    tick();
    inst_addr_ok = 1'b0;
    settle();
    chk("t2.consumed", {31'd0, if_valid}, 32'd0);

    // 3: redirect while a read is outstanding
    redir = 1'b1; redir_pc = 32'h8000_0100;
    settle();
    chk("t3.req_redir", {31'd0, inst_req}, 32'd0);
    tick();
    redir = 1'b0;
    tick();
    inst_data_ok = 1'b1; inst_rdata = 32'hDEAD_BEEF;
    settle();
    chk("t3.req_wait", {31'd0, inst_req}, 32'd0);
    chk("t3.addr_wait", inst_addr, 32'h8000_0100);
    tick();
    inst_data_ok = 1'b0;
    settle();
    chk("t3.dropped", {31'd0, if_valid}, 32'd0);
    chk("t3.req", {31'd0, inst_req}, 32'd1);
    chk("t3.addr", inst_addr, 32'h8000_0100);

    // 4: redirect coinciding with data_ok
    inst_addr_ok = 1'b1;
    tick();
    inst_addr_ok = 1'b0;
    inst_data_ok = 1'b1; inst_rdata = 32'h1111_1111;
    redir = 1'b1; redir_pc = 32'h8000_0200;
    settle();
    chk("t4.req_redir", {31'd0, inst_req}, 32'd0);
    tick();
    inst_data_ok = 1'b0; redir = 1'b0;
    settle();
    chk("t4.dropped", {31'd0, if_valid}, 32'd0);
    chk("t4.req", {31'd0, inst_req}, 32'd1);
    chk("t4.addr", inst_addr, 32'h8000_0200);
    inst_addr_ok = 1'b1;
    tick();
    inst_addr_ok = 1'b0;
    inst_data_ok = 1'b1; inst_rdata = 32'h8C42_0004;
    exp_q.push_back('{pc: 32'h8000_0200, inst: 32'h8C42_0004, adel: 1'b0});
    tick();
    inst_data_ok = 1'b0;
    settle();
    pop_check("t4.out");

    // 5: misaligned redirect yields an address-error entry and halts
    redir = 1'b1; redir_pc = 32'h8000_0102;
    settle();
    chk("t5.req_redir", {31'd0, inst_req}, 32'd0);
    tick();
    redir = 1'b0;
    exp_q.push_back('{pc: 32'h8000_0102, inst: 32'h0, adel: 1'b1});
    settle();
    chk("t5.squashed", {31'd0, if_valid}, 32'd0);
    chk("t5.req_mis", {31'd0, inst_req}, 32'd0);
    tick();
    pop_check("t5.adel");
    chk("t5.req_halt", {31'd0, inst_req}, 32'd0);
    tick();
    chk("t5.consumed", {31'd0, if_valid}, 32'd0);
    chk("t5.req_halt2", {31'd0, inst_req}, 32'd0);
    tick();
    chk("t5.req_halt3", {31'd0, inst_req}, 32'd0);
    redir = 1'b1; redir_pc = 32'h8000_0180;
    tick();
    redir = 1'b0;
    settle();
    chk("t5.req_resume", {31'd0, inst_req}, 32'd1);
    chk("t5.addr_resume", inst_addr, 32'h8000_0180);
    inst_addr_ok = 1'b1;
    tick();
    inst_addr_ok = 1'b0;
    inst_data_ok = 1'b1; inst_rdata = 32'hAC43_0008;
    exp_q.push_back('{pc: 32'h8000_0180, inst: 32'hAC43_0008, adel: 1'b0});
    tick();
    inst_data_ok = 1'b0;
    settle();
    pop_check("t5.out");

    // 6: slow address accept holds request stable
    for (int i = 0; i < 3; i++) begin
      chk("t6.req_hold", {31'd0, inst_req}, 32'd1);
      chk("t6.addr_hold", inst_addr, 32'h8000_0184);
      tick();
    end
    inst_addr_ok = 1'b1;
    settle();
    chk("t6.req_acc", {31'd0, inst_req}, 32'd1);
    chk("t6.addr_acc", inst_addr, 32'h8000_0184);
    tick();
    inst_addr_ok = 1'b0;
    inst_data_ok = 1'b1; inst_rdata = 32'h3C01_1234;
    exp_q.push_back('{pc: 32'h8000_0184, inst: 32'h3C01_1234, adel: 1'b0});
    settle();
    chk("t6.pc_adv", inst_addr, 32'h8000_0188);
    tick();
    inst_data_ok = 1'b0;
    settle();
    pop_check("t6.out");
    tick();
    chk("t6.consumed", {31'd0, if_valid}, 32'd0);
    chk("sb.empty", exp_q.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/fetch_unit.md
# fetch_unit

Instruction-fetch stage of the MIPS pipeline and the producer side of the instruction word that the decode stage consumes. It holds the PC and issues word reads over a request/address-ok/data-ok instruction-memory interface, with at most one read outstanding. Each returned word is held in a one-entry output register, together with its PC and an address-error flag, until the decode stage accepts it. Redirects (branch, jump, exception, eret) squash in-flight and buffered fetches and restart fetching at a new PC.

## Interface
- `RESET_PC`, default `32'hBFC0_0000`: first fetch address after reset.
- `clk`  in  1: single clock; all state updates on the rising edge.
- `rst_n`  in  1: one clock; reset is asynchronous and active-low.
- `inst_req`  out  1: read request to instruction memory.
- `inst_addr`  out  32: byte address of the read; equals the current PC.
- `inst_addr_ok`  in  1: memory accepts the request this cycle.
- `inst_data_ok`  in  1: read data is valid this cycle. It cannot be back-pressured.
- `inst_rdata`  in  32: returned instruction word.
- `if_valid`  out  1: output register holds an instruction for decode.
- `if_ready`  in  1: decode accepts the instruction this cycle. A transfer occurs when `if_valid & if_ready`.
- `if_pc`  out  32: PC of the buffered instruction.
- `if_inst`  out  32: buffered instruction word.
- `if_adel`  out  1: the buffered entry is a fetch address error (PC not word-aligned).
- `redir`  in  1: single-cycle redirect pulse.
- `redir_pc`  in  32: new fetch PC; sampled only when `redir` is high.

## Operation
- State machine: REQ, WAIT, HALT. Internal registers: `pc`, `drop`, and the output register (`if_valid`, `if_pc`, `if_inst`, `if_adel`).
- The output slot is free when `!if_valid | if_ready`.
- `inst_req = (state==REQ) & slot free & !redir & (pc[1:0]==0)`. `inst_addr = pc` at all times.
- **REQ**
  - If `inst_req & inst_addr_ok`: go to WAIT and set `pc <= pc + 4` (32-bit wrap, no carry out).
  - If `pc[1:0]!=0`, slot free and no `redir`: no memory request. Load the output register with `if_valid=1`, `if_pc=pc`, `if_inst=0`, `if_adel=1`, then go to HALT.
- **WAIT**
  - On `inst_data_ok` with `drop=0`: load `if_valid=1`, `if_pc=pc-4`, `if_inst=inst_rdata`, `if_adel=0`, then go to REQ.
  - On `inst_data_ok` with `drop=1`: discard the data, clear `drop`, go to REQ.
- **HALT**: no requests. Leave only on `redir`.
- **Redirect** (highest priority, any state): `pc <= redir_pc` and `if_valid <= 0`.
  - In REQ: no request is issued that cycle (`inst_req` is forced low).
  - In WAIT without `inst_data_ok` that cycle: set `drop <= 1` and stay in WAIT.
  - In WAIT with `inst_data_ok` the same cycle: discard the data, go to REQ, `drop` stays 0.
  - In HALT: go to REQ.
- **Redirect together with `if_valid & if_ready`**: the transfer to decode still counts as done. Squashing that instruction is decode's responsibility.
- **Output register**: when `if_valid & if_ready` and no new load that cycle, `if_valid <= 0`. A load and a consume in the same cycle replace the entry.
- **No overrun**: a request is only issued when the slot is free, so `inst_data_ok` can never arrive while a non-consumed entry is pending.

## Timing
- **Reset**: `pc=RESET_PC`, state REQ, `drop=0`, `if_valid=0`, `if_pc=0`, `if_inst=0`, `if_adel=0`. `inst_req` is 0 while `rst_n` is low.
  - Reset applied mid-operation abandons any outstanding read. The memory side is reset by the same `rst_n`.
- **Request phase**: `inst_req` and `inst_addr` are combinational from registered state, `redir` and `if_ready`.
  - They hold stable while waiting for `inst_addr_ok`, unless `redir` fires or the slot becomes occupied.
- **Latency**: `inst_data_ok` in cycle N gives `if_valid=1` in cycle N+1.
  - With zero-wait memory (`addr_ok` in the request cycle, `data_ok` the next cycle): one instruction every 2 cycles.
- **Outstanding reads**: at most 1 at any time.
- **Misaligned PC**: the `if_adel` entry appears the cycle after REQ sees a free slot.

## Test plan
1. **Reset and first fetch**: release `rst_n`, `addr_ok=1` immediately, `data_ok` one cycle later with `32'h24020001` -> `inst_addr=BFC00000`; then `if_valid=1`, `if_pc=BFC00000`, `if_inst=24020001`, `if_adel=0`; next `inst_addr=BFC00004`.
2. **Decode stall**: `if_ready=0` for 5 cycles after an instruction is buffered -> `if_valid`, `if_pc`, `if_inst` stay constant and `inst_req=0` throughout; `inst_req` rises in the cycle `if_ready=1`.
3. **Redirect during WAIT**: `redir` with `redir_pc=80000100`, then `data_ok` 2 cycles later with `32'hDEADBEEF` -> no `if_valid` for `DEADBEEF`; next `inst_addr=80000100`.
4. **Redirect on the `data_ok` cycle**: `redir` with `80000200` in the same cycle as `data_ok` -> data dropped; `inst_req` with `inst_addr=80000200` the following cycle; `drop` never set (a subsequent `data_ok` is delivered).
5. **Misaligned redirect**: `redir_pc=80000102` -> next cycle `if_valid=1`, `if_adel=1`, `if_pc=80000102`, `if_inst=0`; `inst_req` stays 0 until a redirect to `80000180`, which then fetches `80000180`.
6. **Slow address accept**: `inst_addr_ok` held low for 3 cycles -> `inst_req=1` and `inst_addr` constant for 4 cycles; `pc` advances by exactly 4 after the accept.
